// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream through a two-entry registered buffer.
// Define FIFO_STREAM_READER_LAST_EN to enable the packet beat counter driving m_last_o.
module fifo_stream_reader #(
   parameter int DW     = 32,
   parameter int BEAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     fifo_data_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rd_en_o,
   input  logic              flush_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DW-1:0]     m_data_o,
   output logic              m_last_o,
   input  logic [BEAT_W-1:0] burst_len_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t        state_p0, state_nxt;
   logic [DW-1:0] main_p1, skid_p0;
   logic          push, pop;
   logic          ld_main_fifo, ld_main_skid, ld_skid;

   // Pop decision uses only registered state so m_ready_i never reaches the FIFO combinationally
   assign fifo_rd_en_o = ~fifo_empty_i & (state_p0 != S_TWO) & ~flush_i & ~rst;
   assign m_valid_o    = (state_p0 != S_EMPTY);
   assign busy_o       = m_valid_o;
   assign m_data_o     = main_p1;
   assign push         = fifo_rd_en_o;
   assign pop          = m_valid_o & m_ready_i;

   always_comb begin
      state_nxt    = state_p0;
      ld_main_fifo = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush_i) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state_p0)
            S_EMPTY: begin
               if (push) begin
                  state_nxt    = S_ONE;
                  ld_main_fifo = 1'b1;
               end
            end
            S_ONE: begin
               if (push && !pop) begin
                  state_nxt = S_TWO;
                  ld_skid   = 1'b1;
               end else if (push && pop) begin
                  ld_main_fifo = 1'b1;
               end else if (pop) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (pop) begin
                  state_nxt    = S_ONE;
                  ld_main_skid = 1'b1;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_p0 <= S_EMPTY;
      else     state_p0 <= state_nxt;
   end

   // Output stage: main register is cleared on reset so m_data_o reads 0 afterwards
   always_ff @(posedge clk) begin
      if (rst)               main_p1 <= '0;
      else if (ld_main_fifo) main_p1 <= fifo_data_i;
      else if (ld_main_skid) main_p1 <= skid_p0;
   end

   always_ff @(posedge clk) begin
      if (ld_skid) skid_p0 <= fifo_data_i;
   end

`ifdef FIFO_STREAM_READER_LAST_EN
   localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};

   logic [BEAT_W-1:0] beat_cnt_p0, eff_len;

   // Live compare: shrinking burst_len_i mid-packet closes the packet on the next beat
   assign eff_len  = (burst_len_i == '0) ? BEAT_ONE : burst_len_i;
   assign m_last_o = m_valid_o & (beat_cnt_p0 >= (eff_len - BEAT_ONE));

   always_ff @(posedge clk) begin
      if (rst || flush_i) beat_cnt_p0 <= '0;
      else if (pop)       beat_cnt_p0 <= m_last_o ? '0 : (beat_cnt_p0 + BEAT_ONE);
   end
`else
   logic unused_burst_len;

   assign unused_burst_len = ^burst_len_i;
   assign m_last_o         = 1'b0;
`endif

endmodule
